// File: rtl/phy_rx_deserializer.sv
// phy_rx_deserializer
// Serial-to-parallel lane receiver. It hunts for a comma symbol to find word
// alignment, confirms it over LOCK_COUNT aligned commas, and then delivers
// words with one-cycle valid pulses. While locked it counts commas that land
// off the word grid and drops back to hunting after LOSS_COUNT in a row.
module phy_rx_deserializer #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             default_values,
  input  logic             data_in,
  output logic             active,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic             err,
  output logic [1:0]       lock_state
);

  localparam int BCW = $clog2(WIDTH);
  localparam int CCW = $clog2(LOCK_COUNT) + 1;
  localparam int MCW = $clog2(LOSS_COUNT) + 1;

  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [CCW-1:0] LOCK_LIM = CCW'(LOCK_COUNT);
  localparam logic [MCW-1:0] LOSS_LIM = MCW'(LOSS_COUNT);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [WIDTH-1:0] r_sr;
  logic [BCW-1:0]   r_bitCnt;
  logic [CCW-1:0]   r_commaCnt;
  logic [MCW-1:0]   r_missCnt;
  logic [1:0]       r_state;
  logic             r_active;
  logic             r_valid;
  logic             r_err;
  logic [WIDTH-1:0] r_dataOut;

  logic             w_isComma;
  logic             w_lastBit;
  logic [BCW-1:0]   w_bitNext;
  logic [CCW-1:0]   w_commaNext;
  logic [MCW-1:0]   w_missNext;

  // All decisions look at the shift register as it stood before the edge.
  assign w_isComma   = (r_sr == COMMA);
  assign w_lastBit   = (r_bitCnt == LAST_BIT);
  assign w_bitNext   = w_lastBit ? '0 : (r_bitCnt + BCW'(1));
  assign w_commaNext = r_commaCnt + CCW'(1);
  assign w_missNext  = r_missCnt + MCW'(1);

  // Serial bits enter at the LSB so the oldest bit ends up at the MSB.
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[WIDTH-2:0], data_in};
    end
  end

  // Alignment FSM: bit counter, comma/miss counters, word capture and pulses.
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_bitCnt   <= '0;
      r_commaCnt <= '0;
      r_missCnt  <= '0;
      r_state    <= ST_HUNT;
      r_active   <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_dataOut  <= '0;
    end else begin
      r_bitCnt <= w_bitNext;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (w_isComma) begin
            r_bitCnt   <= '0;
            r_commaCnt <= CCW'(1);
            r_dataOut  <= r_sr;
            if (LOCK_COUNT == 1) begin
              r_state  <= ST_LOCKED;
              r_active <= 1'b1;
            end else begin
              r_state <= ST_SYNC;
            end
          end
        end
        ST_SYNC: begin
          if (w_lastBit) begin
            if (w_isComma) begin
              r_commaCnt <= w_commaNext;
              r_dataOut  <= r_sr;
              if (w_commaNext == LOCK_LIM) begin
                r_state  <= ST_LOCKED;
                r_active <= 1'b1;
              end
            end else begin
              r_state    <= ST_HUNT;
              r_commaCnt <= '0;
            end
          end else if (w_isComma) begin
            r_bitCnt   <= '0;
            r_commaCnt <= CCW'(1);
          end
        end
        ST_LOCKED: begin
          if (w_lastBit) begin
            r_dataOut <= r_sr;
            if (w_isComma) begin
              r_missCnt <= '0;
            end else begin
              r_valid <= 1'b1;
            end
          end else if (w_isComma) begin
            r_err     <= 1'b1;
            r_missCnt <= w_missNext;
            if (w_missNext == LOSS_LIM) begin
              r_state    <= ST_HUNT;
              r_active   <= 1'b0;
              r_commaCnt <= '0;
              r_missCnt  <= '0;
              r_valid    <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= ST_HUNT;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign active     = r_active;
  assign valid      = r_valid;
  assign data_out   = r_dataOut;
  assign err        = r_err;
  assign lock_state = r_state;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// tb_phy_rx_deserializer
// Drives an 8-bit (default) receiver and a 10-bit receiver from one bit clock.
// Word-level vectors record what should be visible right after the first bit
// of each word is clocked in, i.e. the receiver's verdict on the word before.
module tb_phy_rx_deserializer;

  typedef struct {
    logic       rstFirst;
    logic [7:0] word;
    int         expValid;
    logic [7:0] expData;
    logic       expActive;
    logic [1:0] expState;
    int         expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst8, din8, rst10, din10;
  logic        active8, valid8, err8, active10, valid10, err10;
  logic [7:0]  dout8;
  logic [9:0]  dout10;
  logic [1:0]  state8, state10;

  int          checkCount = 0;
  int          passCount  = 0;
  int          vCnt, eCnt, errTotal, validTotal;
  logic        v0, a0;
  logic [15:0] d0;
  logic [1:0]  s0;
  vec_t        tbl[20];

  phy_rx_deserializer dut8 (
    .clk_32f(clk), .default_values(rst8), .data_in(din8),
    .active(active8), .valid(valid8), .data_out(dout8),
    .err(err8), .lock_state(state8)
  );

  phy_rx_deserializer #(
    .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(2), .LOSS_COUNT(4)
  ) dut10 (
    .clk_32f(clk), .default_values(rst10), .data_in(din10),
    .active(active10), .valid(valid10), .data_out(dout10),
    .err(err10), .lock_state(state10)
  );

  // Free-running bit clock shared by both receivers.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic sendBit8(input logic b);
    din8 = b;
    @(posedge clk);
    #1;
  endtask

  // Shift one word in MSB first; record pulse counts over the word and the
  // outputs seen right after its first bit.
  task automatic applyStimulus(input int sel, input logic [15:0] word);
    int n;
    n    = (sel == 0) ? 8 : 10;
    vCnt = 0;
    eCnt = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (sel == 0) din8 = word[i];
      else          din10 = word[i];
      @(posedge clk);
      #1;
      if (sel == 0) begin
        vCnt = vCnt + (valid8 ? 1 : 0);
        eCnt = eCnt + (err8 ? 1 : 0);
        if (i == n - 1) begin
          v0 = valid8; d0 = 16'(dout8); a0 = active8; s0 = state8;
        end
      end else begin
        vCnt = vCnt + (valid10 ? 1 : 0);
        eCnt = eCnt + (err10 ? 1 : 0);
        if (i == n - 1) begin
          v0 = valid10; d0 = 16'(dout10); a0 = active10; s0 = state10;
        end
      end
    end
  endtask

  task automatic fillTable();
    // lock acquisition, data words, idle commas between data
    tbl[0]  = '{1'b0, 8'hBC, 0, 8'h00, 1'b0, 2'd0, 0};
    tbl[1]  = '{1'b0, 8'hBC, 0, 8'hBC, 1'b0, 2'd1, 0};
    tbl[2]  = '{1'b0, 8'hBC, 0, 8'hBC, 1'b0, 2'd1, 0};
    tbl[3]  = '{1'b0, 8'hBC, 0, 8'hBC, 1'b0, 2'd1, 0};
    tbl[4]  = '{1'b0, 8'h5A, 0, 8'hBC, 1'b1, 2'd2, 0};
    tbl[5]  = '{1'b0, 8'hC3, 1, 8'h5A, 1'b1, 2'd2, 0};
    tbl[6]  = '{1'b0, 8'hBC, 1, 8'hC3, 1'b1, 2'd2, 0};
    tbl[7]  = '{1'b0, 8'h00, 0, 8'hBC, 1'b1, 2'd2, 0};
    tbl[8]  = '{1'b0, 8'hBC, 1, 8'h00, 1'b1, 2'd2, 0};
    tbl[9]  = '{1'b0, 8'hFF, 0, 8'hBC, 1'b1, 2'd2, 0};
    tbl[10] = '{1'b0, 8'h3C, 1, 8'hFF, 1'b1, 2'd2, 0};
    // SYNC abort on a non-comma word, then a fresh four-comma lock
    tbl[11] = '{1'b1, 8'hBC, 0, 8'h00, 1'b0, 2'd0, 0};
    tbl[12] = '{1'b0, 8'hBC, 0, 8'hBC, 1'b0, 2'd1, 0};
    tbl[13] = '{1'b0, 8'h11, 0, 8'hBC, 1'b0, 2'd1, 0};
    tbl[14] = '{1'b0, 8'hBC, 0, 8'hBC, 1'b0, 2'd0, 0};
    tbl[15] = '{1'b0, 8'hBC, 0, 8'hBC, 1'b0, 2'd1, 0};
    tbl[16] = '{1'b0, 8'hBC, 0, 8'hBC, 1'b0, 2'd1, 0};
    tbl[17] = '{1'b0, 8'hBC, 0, 8'hBC, 1'b0, 2'd1, 0};
    tbl[18] = '{1'b0, 8'h42, 0, 8'hBC, 1'b1, 2'd2, 0};
    tbl[19] = '{1'b0, 8'h00, 1, 8'h42, 1'b1, 2'd2, 0};
  endtask

  task automatic runTable(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].rstFirst) begin
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
      end
      applyStimulus(0, {8'h00, tbl[i].word});
      checkOutput($sformatf("vec%0d valid count", i), vCnt, tbl[i].expValid);
      checkOutput($sformatf("vec%0d valid slot", i), 32'(v0), tbl[i].expValid);
      checkOutput($sformatf("vec%0d data_out", i), 32'(d0), 32'(tbl[i].expData));
      checkOutput($sformatf("vec%0d active", i), 32'(a0), 32'(tbl[i].expActive));
      checkOutput($sformatf("vec%0d lock_state", i), 32'(s0), 32'(tbl[i].expState));
      checkOutput($sformatf("vec%0d err count", i), eCnt, tbl[i].expErr);
    end
  endtask

  // Main sequence: reset, table vectors, hand-written corner cases, 10-bit lane.
  initial begin
    rst8 = 1'b1; rst10 = 1'b1; din8 = 1'b0; din10 = 1'b0;
    fillTable();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset active", 32'(active8), 0);
    checkOutput("reset valid", 32'(valid8), 0);
    checkOutput("reset data_out", 32'(dout8), 0);
    checkOutput("reset err", 32'(err8), 0);
    checkOutput("reset lock_state", 32'(state8), 0);
    rst8 = 1'b0;

    sendBit8(1'b1); sendBit8(1'b0); sendBit8(1'b1);
    runTable(0, 10);

    // four commas three bits off the word grid force loss of lock
    errTotal = 0;
    for (int k = 0; k < 3; k++) begin
      sendBit8(1'b0);
      errTotal = errTotal + (err8 ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 16'h00BC);
      errTotal = errTotal + eCnt;
    end
    checkOutput("loss err before last", errTotal, 3);
    checkOutput("loss still locked", 32'(state8), 2);
    sendBit8(1'b0);
    checkOutput("loss last err pulse", 32'(err8), 1);
    errTotal = errTotal + (err8 ? 1 : 0);
    checkOutput("loss err total", errTotal, 4);
    checkOutput("loss lock_state", 32'(state8), 0);
    checkOutput("loss active", 32'(active8), 0);

    // relock, then offset commas each followed by an aligned comma keep lock
    for (int k = 0; k < 4; k++) applyStimulus(0, 16'h00BC);
    errTotal = 0;
    validTotal = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 16'h0017);
      checkOutput($sformatf("miss reset lock %0d", k), 32'(s0), 2);
      errTotal = errTotal + eCnt; validTotal = validTotal + vCnt;
      applyStimulus(0, 16'h0080);
      errTotal = errTotal + eCnt; validTotal = validTotal + vCnt;
      applyStimulus(0, 16'h00BC);
      errTotal = errTotal + eCnt; validTotal = validTotal + vCnt;
    end
    applyStimulus(0, 16'h005A);
    checkOutput("miss reset state", 32'(s0), 2);
    checkOutput("miss reset active", 32'(a0), 1);
    checkOutput("miss reset err total", errTotal, 4);
    checkOutput("miss reset valid total", validTotal, 8);

    // reset lands on the edge that would pulse valid for 0x5A
    din8 = 1'b0;
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    checkOutput("midlock reset active", 32'(active8), 0);
    checkOutput("midlock reset valid", 32'(valid8), 0);
    checkOutput("midlock reset data_out", 32'(dout8), 0);
    checkOutput("midlock reset lock_state", 32'(state8), 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 16'h00BC);
    applyStimulus(0, 16'h00BC);
    checkOutput("relock after 3 commas state", 32'(s0), 1);
    checkOutput("relock after 3 commas active", 32'(a0), 0);
    applyStimulus(0, 16'h0042);
    checkOutput("relock after 4 commas state", 32'(s0), 2);
    checkOutput("relock after 4 commas active", 32'(a0), 1);

    runTable(11, 19);

    // 10-bit lane with a two-comma lock
    checkOutput("w10 reset lock_state", 32'(state10), 0);
    checkOutput("w10 reset active", 32'(active10), 0);
    checkOutput("w10 reset data_out", 32'(dout10), 0);
    rst10 = 1'b0;
    applyStimulus(1, 16'h017C);
    checkOutput("w10 hunt", 32'(s0), 0);
    applyStimulus(1, 16'h017C);
    checkOutput("w10 sync", 32'(s0), 1);
    checkOutput("w10 sync data", 32'(d0), 32'h17C);
    applyStimulus(1, 16'h02A5);
    checkOutput("w10 locked", 32'(s0), 2);
    checkOutput("w10 locked active", 32'(a0), 1);
    checkOutput("w10 no valid on comma", 32'(v0), 0);
    applyStimulus(1, 16'h00F0);
    checkOutput("w10 word1 valid", 32'(v0), 1);
    checkOutput("w10 word1 data", 32'(d0), 32'h2A5);
    checkOutput("w10 word1 pulses", vCnt, 1);
    applyStimulus(1, 16'h0000);
    checkOutput("w10 word2 valid", 32'(v0), 1);
    checkOutput("w10 word2 data", 32'(d0), 32'h0F0);
    checkOutput("w10 word2 pulses", vCnt, 1);
    checkOutput("w10 err", eCnt, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
